// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-way round-robin arbiter with bounded tenure (MAX_HOLD).
// Ports: clk, rst_n (async, active-low), req[N], lock (only with RR_ARB_LOCK_EN),
//        gnt[N] one-hot, gnt_valid, gnt_id, hold_cnt[8]; all outputs registered.
// Optional feature macro: RR_ARB_LOCK_EN adds the lock port (tenure extension).
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
`ifdef RR_ARB_LOCK_EN
    input  logic                 lock,
`endif
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic [7:0]           hold_cnt
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;

    logic [IW-1:0] win;
    logic          win_ok;
    logic [IW-1:0] win_nxt;
    logic          owner_req;
    logic          at_max;
    logic          lock_ext;
    logic          do_grant;
    logic          do_idle;
    logic          do_inc;

`ifdef RR_ARB_LOCK_EN
    assign lock_ext = lock;
`else
    assign lock_ext = 1'b0;
`endif

    // Search ptr, ptr+1, ... modulo N. Iterating from the far end lets
    // the closest set bit to ptr overwrite the others.
    always_comb begin
        int j;
        j      = 0;
        win    = '0;
        win_ok = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                win    = IW'(j);
                win_ok = 1'b1;
            end
        end
        win_nxt = (win == IW'(N - 1)) ? '0 : win + 1'b1;
    end

    always_comb begin
        owner_req = req[gnt_id];
        at_max    = (hold_cnt >= 8'(MAX_HOLD));
        // New tenure: from idle, on owner release, or on expiry without lock.
        do_grant  = win_ok &&
                    ((state == IDLE) || !owner_req ||
                     (at_max && !lock_ext));
        do_idle   = (state == GRANT) && !win_ok;
        do_inc    = (state == GRANT) && owner_req && !at_max;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            hold_cnt  <= 8'd0;
        end else if (do_grant) begin
            state     <= GRANT;
            ptr       <= win_nxt;
            gnt       <= {{(N-1){1'b0}}, 1'b1} << win;
            gnt_valid <= 1'b1;
            gnt_id    <= win;
            hold_cnt  <= 8'd1;
        end else if (do_idle) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            hold_cnt  <= 8'd0;
        end else if (do_inc) begin
            hold_cnt  <= hold_cnt + 8'd1;
        end
        // Otherwise: idle with no request, or locked extension at MAX_HOLD.
    end

endmodule
